// File: rtl/aes_inv_cipher_seq.sv
// aes_inv_cipher_seq
//   Iterative AES inverse cipher (AES-128/192/256 via NK/NR). It applies one
//   inverse round per clock using a pre-expanded key schedule and has
//   valid/ready handshakes on both sides.
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_block          ciphertext input handshake
//                                       (bits [0:7] = state byte 0, column-major)
//   key_schedule   round key r at bits [128r +: 128]; must be stable while busy
//   out_valid/out_ready/out_block       plaintext output handshake
//   busy           high in any non-idle state
//   round_idx      index of the round key applied next
module aes_inv_cipher_seq #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [0:127]          in_block,
   input  logic [0:128*(NR+1)-1] key_schedule,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [0:127]          out_block,
   output logic                  busy,
   output logic [3:0]            round_idx
);

   if (NR != NK + 6) begin : g_bad_params
      $error("aes_inv_cipher_seq: NR must equal NK + 6");
   end

   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   state_t       state_q, state_d;
   logic [0:127] st_q, st_d;
   logic [0:127] out_block_q, out_block_d;
   logic         out_valid_q, out_valid_d;
   logic [3:0]   round_idx_q, round_idx_d;
   logic [0:127] rk_cur, rk_first, rk_last;

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[8*int'(b) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r rotated right by r: new column c takes old column (c - r) mod 4.
   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Multiples 9/b/d/e built from x2, x4, x8 of each byte.
   function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a [4];
      logic [7:0]   m9 [4], mb [4], md [4], me [4];
      logic [7:0]   x2, x4, x8;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = s[8*(4*c+r) +: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
         end
         o[8*(4*c+0) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         o[8*(4*c+1) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         o[8*(4*c+2) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         o[8*(4*c+3) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return o;
   endfunction

   assign rk_cur   = key_schedule[128*int'(round_idx_q) +: 128];
   assign rk_first = key_schedule[0 +: 128];
   assign rk_last  = key_schedule[128*NR +: 128];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         st_q        <= '0;
         out_block_q <= '0;
         out_valid_q <= 1'b0;
         round_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         out_block_q <= out_block_d;
         out_valid_q <= out_valid_d;
         round_idx_q <= round_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      out_block_d = out_block_q;
      out_valid_d = out_valid_q;
      round_idx_d = round_idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d        = in_block ^ rk_last;
               round_idx_d = 4'(NR - 1);
               state_d     = ROUND;
            end
         end
         ROUND: begin
            st_d        = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_cur);
            round_idx_d = round_idx_q - 4'd1;
            if (round_idx_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            out_block_d = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_first;
            out_valid_d = 1'b1;
            round_idx_d = '0;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q != IDLE);
      out_valid = out_valid_q;
      out_block = out_block_q;
      round_idx = round_idx_q;
   end

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// tb_aes_inv_cipher_seq
//   Directed bench for aes_inv_cipher_seq using FIPS-197 vectors on three
//   instances (NR = 10/12/14). Key schedules are expanded here from the
//   cipher keys; plaintexts and latencies are known constants.
module tb_aes_inv_cipher_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         out_ready;
   logic [0:127] in_block;
   logic [2:0]   iv, ir, ov, bz;
   logic [0:127] ob0, ob1, ob2;
   logic [3:0]   ri0, ri1, ri2;
   logic [0:1407] ks10;
   logic [0:1663] ks12;
   logic [0:1919] ks14;
   logic [0:1919] ks_full;
   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:255] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [0:255] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [0:255] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:255] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

   always #5 clk = ~clk;

   aes_inv_cipher_seq #(.NK(4), .NR(10)) dut10 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(in_block),
      .key_schedule(ks10), .out_valid(ov[0]), .out_ready(out_ready), .out_block(ob0),
      .busy(bz[0]), .round_idx(ri0));
   aes_inv_cipher_seq #(.NK(6), .NR(12)) dut12 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(in_block),
      .key_schedule(ks12), .out_valid(ov[1]), .out_ready(out_ready), .out_block(ob1),
      .busy(bz[1]), .round_idx(ri1));
   aes_inv_cipher_seq #(.NK(8), .NR(14)) dut14 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_block(in_block),
      .key_schedule(ks14), .out_valid(ov[2]), .out_ready(out_ready), .out_block(ob2),
      .busy(bz[2]), .round_idx(ri2));

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // Forward S-box from its definition: GF(2^8) inverse then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v = 8'h00;
      for (int i = 1; i < 256; i++)
         if (gmul(x, 8'(i)) == 8'h01) v = 8'(i);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rcon = 8'h01;
      logic [0:1919] ks = '0;
      int            nr = nk + 6;
      for (int i = 0; i < 4*(nr+1); i++) begin
         if (i < nk) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
               rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
               t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
         end
         ks[32*i +: 32] = w[i];
      end
      return ks;
   endfunction

   function automatic logic [127:0] get_ob(input int s);
      case (s)
         0:       return ob0;
         1:       return ob1;
         default: return ob2;
      endcase
   endfunction

   task automatic run_block(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                            input string tag);
      int nr  = 10 + 2*sel;
      int lat = 0;
      check_eq({tag, " in_ready idle"}, 128'(ir[sel]), 128'd1);
      in_block = ct;
      iv[sel]  = 1'b1;
      tick();
      iv[sel]  = 1'b0;
      in_block = {$urandom, $urandom, $urandom, $urandom};
      while (ov[sel] == 1'b0 && lat < 20) begin
         tick();
         lat++;
      end
      check_eq({tag, " latency"}, 128'(lat), 128'(nr));
      check_eq({tag, " plaintext"}, get_ob(sel), pt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, " out_valid drop"}, 128'(ov[sel]), 128'd0);
      check_eq({tag, " in_ready after"}, 128'(ir[sel]), 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int seen;
      int nout;
      reset     = 1'b1;
      iv        = '0;
      out_ready = 1'b0;
      in_block  = '0;
      ks_full = expand(KEY128, 4); ks10 = ks_full[0 +: 1408];
      ks_full = expand(KEY192, 6); ks12 = ks_full[0 +: 1664];
      ks_full = expand(KEY256, 8); ks14 = ks_full[0 +: 1920];
      tick();
      tick();
      reset = 1'b0;
      check_eq("reset out_valid", 128'(ov), 128'd0);
      check_eq("reset in_ready", 128'(ir), 128'h7);
      check_eq("reset busy", 128'(bz), 128'd0);
      check_eq("reset round_idx", 128'({ri0, ri1, ri2}), 128'd0);
      check_eq("reset out_block", ob0, 128'd0);

      // T1..T3: one vector per key size
      run_block(0, CT1, PT1, "T1");
      run_block(1, CT2, PT1, "T2");
      run_block(2, CT3, PT1, "T3");

      // T4: output backpressure
      ks_full = expand(KEYB, 4); ks10 = ks_full[0 +: 1408];
      in_block = CTB;
      iv[0]    = 1'b1;
      tick();
      iv[0] = 1'b0;
      w = 0;
      while (ov[0] == 1'b0 && w < 20) begin
         tick();
         w++;
      end
      check_eq("T4 latency", 128'(w), 128'd10);
      for (int k = 0; k < 6; k++) begin
         check_eq("T4 held out_valid", 128'(ov[0]), 128'd1);
         check_eq("T4 held out_block", ob0, PTB);
         check_eq("T4 held in_ready", 128'(ir[0]), 128'd0);
         if (k < 5) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("T4 in_ready after", 128'(ir[0]), 128'd1);
      check_eq("T4 out_valid after", 128'(ov[0]), 128'd0);
      check_eq("T4 out_block kept", ob0, PTB);

      // T5: reset mid-operation at round_idx 5
      ks_full = expand(KEY128, 4); ks10 = ks_full[0 +: 1408];
      in_block = CT1;
      iv[0]    = 1'b1;
      tick();
      iv[0] = 1'b0;
      w = 0;
      while (ri0 != 4'd5 && w < 20) begin
         tick();
         w++;
      end
      check_eq("T5 cycles to idx5", 128'(w), 128'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("T5 in_ready", 128'(ir[0]), 128'd1);
      check_eq("T5 busy", 128'(bz[0]), 128'd0);
      check_eq("T5 out_valid", 128'(ov[0]), 128'd0);
      check_eq("T5 out_block", ob0, 128'd0);
      check_eq("T5 round_idx", 128'(ri0), 128'd0);
      seen = 0;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (ov[0]) seen++;
      end
      check_eq("T5 abandoned output", 128'(seen), 128'd0);
      run_block(0, CT1, PT1, "T5 fresh");

      // T6: in_valid held high, data changing while busy, out_ready tied high
      out_ready = 1'b1;
      in_block  = CT1;
      iv[0]     = 1'b1;
      tick();
      nout = 0;
      for (int cyc = 1; cyc <= 35; cyc++) begin
         in_block = ir[0] ? CT1 : {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (ov[0]) begin
            check_eq("T6 out cycle", 128'(cyc), 128'(10 + 12*nout));
            check_eq("T6 plaintext", ob0, PT1);
            nout++;
         end
         if (ir[0]) check_eq("T6 ready cycle", 128'(cyc % 12), 128'd11);
      end
      iv[0] = 1'b0;
      check_eq("T6 block count", 128'(nout), 128'd3);
      tick();
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
